// File: rtl/pipeline_hazard_ctrl.sv
// Hazard unit for a 5-stage RISC-V pipeline: forwarding, load-use and
// branch flushes, memory-wait stalls with timeout, and stall/flush stats.
module pipeline_hazard_ctrl #(
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       Rs1D,
    input  logic [4:0]       Rs2D,
    input  logic [4:0]       Rs1E,
    input  logic [4:0]       Rs2E,
    input  logic [4:0]       RdE,
    input  logic [4:0]       RdM,
    input  logic [4:0]       RdW,
    input  logic             ResultSrcE0,
    input  logic             RegWriteM,
    input  logic             RegWriteW,
    input  logic             PCSrcE,
    input  logic             MemAccessM,
    input  logic             mem_ready,
    input  logic             clr_stats,
    output logic             StallF,
    output logic             StallD,
    output logic             StallE,
    output logic             StallM,
    output logic             FlushD,
    output logic             FlushE,
    output logic             FlushW,
    output logic [1:0]       ForwardAE,
    output logic [1:0]       ForwardBE,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count
);

    typedef enum logic [1:0] {RUN, MEM_WAIT, ERROR} state_t;

    localparam logic [7:0] TO = 8'(TIMEOUT);

    state_t     state, state_nxt;
    logic [7:0] wait_cnt, wait_cnt_nxt;
    logic       mem_stall;
    logic       lw_stall;

    function automatic logic [1:0] fwd_sel(input logic [4:0] rs);
        if (RegWriteM && RdM != 5'd0 && RdM == rs)
            return 2'b10;
        else if (RegWriteW && RdW != 5'd0 && RdW == rs)
            return 2'b01;
        else
            return 2'b00;
    endfunction

    assign mem_stall = MemAccessM & ~mem_ready;
    assign lw_stall  = ResultSrcE0 & (RdE != 5'd0) &
                       ((RdE == Rs1D) | (RdE == Rs2D));
    assign halted    = (state == ERROR);

    always_comb begin
        ForwardAE = 2'b00;
        ForwardBE = 2'b00;
        if (!rst) begin
            ForwardAE = fwd_sel(Rs1E);
            ForwardBE = fwd_sel(Rs2E);
        end
    end

    // Halt outranks everything, so a stuck memory freezes the whole pipe
    always_comb begin
        StallF = 1'b0;
        StallD = 1'b0;
        StallE = 1'b0;
        StallM = 1'b0;
        FlushD = 1'b0;
        FlushE = 1'b0;
        FlushW = 1'b0;
        if (!rst) begin
            priority case (1'b1)
                halted, mem_stall: begin
                    StallF = 1'b1;
                    StallD = 1'b1;
                    StallE = 1'b1;
                    StallM = 1'b1;
                    FlushW = 1'b1;
                end
                PCSrcE: begin
                    FlushD = 1'b1;
                    FlushE = 1'b1;
                end
                lw_stall: begin
                    StallF = 1'b1;
                    StallD = 1'b1;
                    FlushE = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        unique case (state)
            RUN: begin
                if (mem_stall) begin
                    state_nxt    = MEM_WAIT;
                    wait_cnt_nxt = 8'd1;
                end
            end
            MEM_WAIT: begin
                if (!mem_stall) begin
                    state_nxt    = RUN;
                    wait_cnt_nxt = 8'd0;
                end else if (wait_cnt == TO) begin
                    state_nxt = ERROR;
                end else begin
                    wait_cnt_nxt = wait_cnt + 8'd1;
                end
            end
            ERROR: state_nxt = ERROR;
            default: begin
                state_nxt    = RUN;
                wait_cnt_nxt = 8'd0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= RUN;
            wait_cnt <= 8'd0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cycles <= '0;
            flush_count  <= '0;
        end else if (clr_stats) begin
            stall_cycles <= '0;
            flush_count  <= '0;
        end else begin
            if (StallF && stall_cycles != '1)
                stall_cycles <= stall_cycles + 1'b1;
            if (FlushD && flush_count != '1)
                flush_count <= flush_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed-vector bench for pipeline_hazard_ctrl with TIMEOUT=4.
module tb_pipeline_hazard_ctrl;

    localparam int CNT_W = 16;

    logic clk = 1'b0;
    logic rst;
    logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
    logic ResultSrcE0, RegWriteM, RegWriteW, PCSrcE;
    logic MemAccessM, mem_ready, clr_stats;
    logic StallF, StallD, StallE, StallM;
    logic FlushD, FlushE, FlushW;
    logic [1:0] ForwardAE, ForwardBE;
    logic halted;
    logic [CNT_W-1:0] stall_cycles, flush_count;

    int n_vec = 0;
    int n_bad = 0;

    pipeline_hazard_ctrl #(.TIMEOUT(4), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
        .RdE(RdE), .RdM(RdM), .RdW(RdW),
        .ResultSrcE0(ResultSrcE0), .RegWriteM(RegWriteM),
        .RegWriteW(RegWriteW), .PCSrcE(PCSrcE),
        .MemAccessM(MemAccessM), .mem_ready(mem_ready),
        .clr_stats(clr_stats),
        .StallF(StallF), .StallD(StallD), .StallE(StallE),
        .StallM(StallM), .FlushD(FlushD), .FlushE(FlushE),
        .FlushW(FlushW), .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .halted(halted), .stall_cycles(stall_cycles),
        .flush_count(flush_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // {StallF,StallD,StallE,StallM,FlushD,FlushE,FlushW}
    function automatic logic [6:0] ctl();
        return {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drv_edge();
        @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        {Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW} = '0;
        {ResultSrcE0, RegWriteM, RegWriteW, PCSrcE} = '0;
        {MemAccessM, clr_stats} = '0;
        mem_ready = 1'b1;
        // Hazard-causing inputs while in reset must stay masked
        RegWriteM = 1'b1; RdM = 5'd5; Rs1E = 5'd5;
        ResultSrcE0 = 1'b1; RdE = 5'd7; Rs1D = 5'd7;
        #3;
        chk("rst_ctl", 32'(ctl()), 32'h00);
        chk("rst_fwd_a", 32'(ForwardAE), 32'h0);
        chk("rst_halted", 32'(halted), 32'h0);
        tick();
        chk("rst_stall_cnt", 32'(stall_cycles), 32'h0);

        drv_edge();
        rst = 1'b0;
        {Rs1D, Rs1E, RdE, RdM} = '0;
        {ResultSrcE0, RegWriteM} = '0;

        // Forwarding: MEM beats WB, x0 never forwards
        drv_edge();
        RegWriteM = 1'b1; RdM = 5'd5; Rs1E = 5'd5;
        RegWriteW = 1'b1; RdW = 5'd5; Rs2E = 5'd5;
        #1;
        chk("fwd_a_mem", 32'(ForwardAE), 32'h2);
        chk("fwd_b_mem", 32'(ForwardBE), 32'h2);
        RdM = 5'd0; #1;
        chk("fwd_a_wb", 32'(ForwardAE), 32'h1);
        chk("fwd_b_wb", 32'(ForwardBE), 32'h1);
        RdW = 5'd0; #1;
        chk("fwd_a_none", 32'(ForwardAE), 32'h0);
        RdW = 5'd5; RegWriteW = 1'b0; #1;
        chk("fwd_b_nowe", 32'(ForwardBE), 32'h0);
        {RegWriteM, RegWriteW, RdM, RdW, Rs1E, Rs2E} = '0;

        // Load-use stall for one cycle
        drv_edge();
        ResultSrcE0 = 1'b1; RdE = 5'd7; Rs2D = 5'd7;
        #1;
        chk("lw_ctl", 32'(ctl()), 32'b1100010);
        chk("lw_cnt0", 32'(stall_cycles), 32'h0);
        tick();
        chk("lw_cnt1", 32'(stall_cycles), 32'h1);
        drv_edge();
        RdE = 5'd0; #1;
        chk("lw_rd0_ctl", 32'(ctl()), 32'h00);
        tick();
        chk("lw_rd0_cnt", 32'(stall_cycles), 32'h1);

        // Branch outranks load-use
        drv_edge();
        RdE = 5'd7; PCSrcE = 1'b1; #1;
        chk("br_ctl", 32'(ctl()), 32'b0000110);
        tick();
        chk("br_flush_cnt", 32'(flush_count), 32'h1);
        chk("br_stall_cnt", 32'(stall_cycles), 32'h1);
        drv_edge();
        {ResultSrcE0, RdE, Rs2D, PCSrcE} = '0;
        clr_stats = 1'b1;
        tick();
        chk("clr_stall", 32'(stall_cycles), 32'h0);
        chk("clr_flush", 32'(flush_count), 32'h0);
        drv_edge();
        clr_stats = 1'b0;

        // Memory wait of exactly TIMEOUT cycles recovers
        MemAccessM = 1'b1; mem_ready = 1'b0; #1;
        chk("mw_ctl", 32'(ctl()), 32'b1111001);
        repeat (4) tick();
        chk("mw4_halted", 32'(halted), 32'h0);
        drv_edge();
        mem_ready = 1'b1; #1;
        chk("mw_rel_ctl", 32'(ctl()), 32'h00);
        tick();
        chk("mw_halted", 32'(halted), 32'h0);
        chk("mw_stall_cnt", 32'(stall_cycles), 32'h4);

        // TIMEOUT+1 stalled cycles trips the error
        drv_edge();
        mem_ready = 1'b0;
        repeat (4) tick();
        chk("to4_halted", 32'(halted), 32'h0);
        tick();
        chk("to5_halted", 32'(halted), 32'h1);
        drv_edge();
        mem_ready = 1'b1; MemAccessM = 1'b0; PCSrcE = 1'b1;
        RegWriteW = 1'b1; RdW = 5'd3; Rs1E = 5'd3;
        #1;
        chk("err_ctl", 32'(ctl()), 32'b1111001);
        chk("err_fwd", 32'(ForwardAE), 32'h1);
        tick();
        chk("err_sticky", 32'(halted), 32'h1);
        chk("err_stall_cnt", 32'(stall_cycles), 32'd10);

        // Async reset out of ERROR
        drv_edge();
        rst = 1'b1; #1;
        chk("rst_halted2", 32'(halted), 32'h0);
        chk("rst_stall2", 32'(stall_cycles), 32'h0);
        chk("rst_flush2", 32'(flush_count), 32'h0);
        chk("rst_ctl2", 32'(ctl()), 32'h00);
        chk("rst_fwd2", 32'(ForwardAE), 32'h0);
        drv_edge();
        rst = 1'b0;
        {PCSrcE, RegWriteW, RdW, Rs1E} = '0;

        // Saturation then clear with StallF still high
        ResultSrcE0 = 1'b1; RdE = 5'd9; Rs1D = 5'd9;
        tick();
        chk("post_rst_cnt", 32'(stall_cycles), 32'h1);
        repeat ((1 << CNT_W) + 2) tick();
        chk("sat_cnt", 32'(stall_cycles), 32'hFFFF);
        drv_edge();
        clr_stats = 1'b1;
        tick();
        chk("sat_clr", 32'(stall_cycles), 32'h0);
        drv_edge();
        clr_stats = 1'b0;
        tick();
        chk("sat_resume", 32'(stall_cycles), 32'h1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
